// File: rtl/ieee754_pkg.sv
// ieee754_pkg: shared field widths, integer limits and FSM states for the float/int converters
package ieee754_pkg;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam int BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam int INT_W = 32;
  localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;
  typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, SIGN, OUT} state_t;
endpackage

// File: rtl/ieee754_classify.sv
// ieee754_classify: decodes exponent/mantissa into special-case flags, unbiased exponent and shift plan
module ieee754_classify
  import ieee754_pkg::*;
(
  input  logic [EXP_W-1:0]        exp_i,
  input  logic [MANT_W-1:0]       mant_i,
  output logic                    is_nan_o,
  output logic                    is_inf_o,
  output logic                    is_zero_or_denorm_o,
  output logic signed [EXP_W:0]   e_o,
  output logic [4:0]              cnt_o,
  output logic                    left_o
);
  logic signed [EXP_W:0] d;
  assign is_nan_o = exp_i == EXP_W'(EXP_MAX) && |mant_i;
  assign is_inf_o = exp_i == EXP_W'(EXP_MAX) && !(|mant_i);
  assign is_zero_or_denorm_o = exp_i == '0;
  assign e_o = $signed({1'b0, exp_i}) - (EXP_W+1)'(BIAS);
  // distance of the binary point from the mantissa LSB; only meaningful for 0 <= e <= 30
  assign d = e_o - (EXP_W+1)'(MANT_W);
  assign cnt_o = 5'(d[EXP_W] ? -d : d);
  assign left_o = !d[EXP_W] && d != '0;
endmodule

// File: rtl/ieee754_to_int.sv
// ieee754_to_int: iterative single-precision float to int32 converter, truncating toward zero
module ieee754_to_int
  import ieee754_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ieee754,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] result,
  output logic             invalid,
  output logic             inexact
);
  state_t state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [INT_W-1:0] acc_q, acc_d, res_q, res_d;
  logic [4:0] cnt_q, cnt_d, cnt;
  logic dir_q, dir_d, sticky_q, sticky_d, inv_q, inv_d, inx_q, inx_d;
  logic is_nan, is_inf, is_zd, left, neg, big, is_min, special;
  logic signed [EXP_W:0] e;
  ieee754_classify u_cls (
    .exp_i(word_q[30:23]),
    .mant_i(word_q[22:0]),
    .is_nan_o(is_nan),
    .is_inf_o(is_inf),
    .is_zero_or_denorm_o(is_zd),
    .e_o(e),
    .cnt_o(cnt),
    .left_o(left)
  );
  assign neg = e[EXP_W];
  assign big = e >= 9'sd31;
  assign is_min = word_q[31] && word_q[30:23] == 8'(BIAS + 31) && word_q[22:0] == '0;
  assign special = is_nan | is_inf | is_zd | neg | big;
  // special results are loaded as magnitudes so SIGN's negation leaves them unchanged
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    sticky_d = sticky_q;
    res_d = res_q;
    inv_d = inv_q;
    inx_d = inx_q;
    case (state_q)
      IDLE: begin
        word_d = in_valid ? ieee754 : word_q;
        state_d = in_valid ? CLASSIFY : IDLE;
      end
      CLASSIFY: begin
        inv_d = is_nan | is_inf | (big & !is_min);
        inx_d = 1'b0;
        sticky_d = is_zd ? |word_q[22:0] : neg;
        acc_d = (is_nan | is_zd | neg) ? '0 :
                (is_inf | big) ? (word_q[31] ? INT_MIN : INT_MAX) :
                {8'b0, 1'b1, word_q[22:0]};
        cnt_d = cnt;
        dir_d = left;
        state_d = (special || cnt == 5'd0) ? SIGN : SHIFT;
      end
      SHIFT: begin
        acc_d = dir_q ? acc_q << 1 : acc_q >> 1;
        sticky_d = sticky_q | (!dir_q & acc_q[0]);
        cnt_d = cnt_q - 5'd1;
        state_d = cnt_q == 5'd1 ? SIGN : SHIFT;
      end
      SIGN: begin
        res_d = word_q[31] ? -acc_q : acc_q;
        inx_d = sticky_q;
        state_d = OUT;
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
      sticky_q <= 1'b0;
      res_q <= '0;
      inv_q <= 1'b0;
      inx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      sticky_q <= sticky_d;
      res_q <= res_d;
      inv_q <= inv_d;
      inx_q <= inx_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign result = res_q;
  assign invalid = inv_q;
  assign inexact = inx_q;
endmodule

// File: tb/tb_ieee754_to_int.sv
// tb_ieee754_to_int: directed vectors feed a scoreboard queue; a monitor pops and checks on each handshake
module tb_ieee754_to_int;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] ieee754 = '0;
  logic in_ready, out_valid, invalid, inexact;
  logic [31:0] result;
  typedef struct {
    logic [31:0] r;
    logic inv;
    logic inx;
    int lat;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
  bit seen = 0, prev_hs = 0;

  ieee754_to_int dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ieee754(ieee754),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .invalid(invalid), .inexact(inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
      prev_hs = 0;
    end else begin
      if (prev_hs) check("ready_after_hs", {30'b0, in_ready, out_valid}, 32'b10);
      prev_hs = 0;
      if (in_valid && in_ready) acc_cyc = cyc + 1;
      if (out_valid) begin
        if (sb.size() == 0) check("unexpected_out", result, 32'hxxxx_xxxx);
        else begin
          if (!seen) check("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
          seen = 1;
          check("result", result, sb[0].r);
          check("flags", {30'b0, invalid, inexact}, {30'b0, sb[0].inv, sb[0].inx});
          check("busy_ready", {31'b0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
            prev_hs = 1;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic [31:0] r, input logic inv, input logic inx,
                      input int lat, input bit hold);
    int n = 0;
    exp_t x;
    @(posedge clk);
    #1;
    ieee754 = w;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    x.r = r;
    x.inv = inv;
    x.inx = inx;
    x.lat = lat;
    sb.push_back(x);
    ieee754 = 32'hDEAD_BEEF;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_state", {result[30:0], in_ready, out_valid, invalid, inexact}, {31'b0, 1'b1, 3'b0});
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    send(32'h3F80_0000, 32'h0000_0001, 0, 0, 25, 0); drain();
    send(32'h4640_E400, 32'h0000_3039, 0, 0, 12, 0); drain();
    send(32'hC040_0000, 32'hFFFF_FFFD, 0, 0, 24, 0); drain();
    send(32'h3FC0_0000, 32'h0000_0001, 0, 1, 25, 0); drain();
    send(32'hBF00_0000, 32'h0000_0000, 0, 1, 2, 0); drain();
    send(32'hCF00_0000, 32'h8000_0000, 0, 0, 2, 0); drain();
    send(32'h4F00_0000, 32'h7FFF_FFFF, 1, 0, 2, 0); drain();
    send(32'hFF80_0000, 32'h8000_0000, 1, 0, 2, 0); drain();
    send(32'h7FC0_0000, 32'h0000_0000, 1, 0, 2, 0); drain();
    send(32'h7F80_0000, 32'h7FFF_FFFF, 1, 0, 2, 0); drain();
    send(32'hCF00_0001, 32'h8000_0000, 1, 0, 2, 0); drain();
    send(32'h0000_0001, 32'h0000_0000, 0, 1, 2, 0); drain();
    send(32'h4EFF_FFFF, 32'h7FFF_FF80, 0, 0, 9, 0); drain();
    send(32'hBFE0_0000, 32'hFFFF_FFFF, 0, 1, 25, 0); drain();
    send(32'h4B00_0000, 32'h0080_0000, 0, 0, 2, 0); drain();
    // back-to-back with in_valid held high
    send(32'h4640_E400, 32'h0000_3039, 0, 0, 12, 1);
    send(32'hC040_0000, 32'hFFFF_FFFD, 0, 0, 24, 1);
    send(32'h3FC0_0000, 32'h0000_0001, 0, 1, 25, 1);
    send(32'h4B00_0001, 32'h0080_0001, 0, 0, 2, 1);
    send(32'h4AFF_FFFF, 32'h007F_FFFF, 0, 1, 3, 0);
    drain();
    // output backpressure
    out_ready = 1'b0;
    send(32'h47C3_5000, 32'h0001_86A0, 0, 0, 9, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check("stall_valid", {31'b0, out_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    // reset mid-shift aborts the conversion
    send(32'h3F80_0000, 32'h0000_0001, 0, 0, 25, 0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_state", {29'b0, in_ready, out_valid, invalid}, {29'b0, 1'b1, 2'b0});
    check("abort_result", result, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(32'h8000_0000, 32'h0000_0000, 0, 0, 2, 0); drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
